md_sequencer: RTL and testbench

//  Multi-cycle MULT/DIV sequencer with the HI/LO register pair. It sits beside the EX-stage ALU.
//  The instruction decoder supplies an md_op code. This block starts the iterative multiply/divide

---
 rtl/md_sequencer_pkg.sv | 41 ++++
 rtl/md_sequencer_if.sv | 30 +++
 rtl/md_sequencer_div_step.sv | 24 ++
 rtl/md_sequencer.sv | 178 +++++++++++++++++
 tb/tb_md_sequencer.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/md_sequencer_pkg.sv
// Shared definitions for the MULT/DIV sequencer: op codes, FSM states,
// the EX result-mux leg for md_rdata and small op-decode helpers.
package md_sequencer_pkg;

    localparam int MD_OP_BIT = 4;

    typedef enum logic [MD_OP_BIT-1:0] {
        MD_OP_NOP   = 4'd0,
        MD_OP_MULT  = 4'd1,
        MD_OP_MULTU = 4'd2,
        MD_OP_DIV   = 4'd3,
        MD_OP_DIVU  = 4'd4,
        MD_OP_MFHI  = 4'd5,
        MD_OP_MFLO  = 4'd6,
        MD_OP_MTHI  = 4'd7,
        MD_OP_MTLO  = 4'd8
    } md_op_e;

    typedef enum logic [1:0] {
        MD_ST_IDLE    = 2'd0,
        MD_ST_RUN_MUL = 2'd1,
        MD_ST_RUN_DIV = 2'd2
    } md_state_e;

    // Select code of the EX result mux leg that forwards md_rdata.
    localparam logic [2:0] MUX_EX_RESULT_MD = 3'd4;

    function automatic logic op_is_mul(input logic [MD_OP_BIT-1:0] op);
        return (op == MD_OP_MULT) || (op == MD_OP_MULTU);
    endfunction

    function automatic logic op_is_div(input logic [MD_OP_BIT-1:0] op);
        return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
    endfunction

    // MULT and DIV treat their operands as two's complement.
    function automatic logic op_is_signed(input logic [MD_OP_BIT-1:0] op);
        return (op == MD_OP_MULT) || (op == MD_OP_DIV);
    endfunction

endpackage

// File: rtl/md_sequencer_if.sv
// EX-stage <-> MULT/DIV sequencer bundle. The pipeline side is the master,
// the sequencer is the slave.
interface md_sequencer_if #(
    parameter int DATA_W = 32
);
    import md_sequencer_pkg::*;

    logic                 md_valid;
    logic [MD_OP_BIT-1:0] md_op;
    logic [DATA_W-1:0]    src_a;
    logic [DATA_W-1:0]    src_b;
    logic                 md_kill;
    logic                 md_stall;
    logic                 md_busy;
    logic                 md_done;
    logic [DATA_W-1:0]    md_rdata;
    logic [DATA_W-1:0]    hi;
    logic [DATA_W-1:0]    lo;

    modport master (
        output md_valid, md_op, src_a, src_b, md_kill,
        input  md_stall, md_busy, md_done, md_rdata, hi, lo
    );

    modport slave (
        input  md_valid, md_op, src_a, src_b, md_kill,
        output md_stall, md_busy, md_done, md_rdata, hi, lo
    );

endinterface

// File: rtl/md_sequencer_div_step.sv
// One restoring-division step on unsigned magnitudes: shift the next dividend
// bit (MSB of quo) into the partial remainder, subtract the divisor if it fits,
// and shift the resulting quotient bit into quo from the right.
module md_sequencer_div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem_i,
    input  logic [DATA_W-1:0] quo_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [DATA_W-1:0] rem_o,
    output logic [DATA_W-1:0] quo_o
);

    logic [DATA_W:0] shifted;
    logic [DATA_W:0] diff;

    // Partial remainder is always < divisor, so one extra bit holds the shift
    // and diff[DATA_W] acts as the borrow (divisor did not fit).
    assign shifted = {rem_i, quo_i[DATA_W-1]};
    assign diff    = shifted - {1'b0, divisor_i};
    assign rem_o   = diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
    assign quo_o   = {quo_i[DATA_W-2:0], ~diff[DATA_W]};

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle MULT/DIV sequencer with the architectural HI/LO pair.
// Multiply: the 64-bit product is registered at issue and committed after
// MUL_CYCLES. Divide: one restoring step per cycle on magnitudes, signs
// applied on the final cycle. Later md ops stall while an op is running.
module md_sequencer
    import md_sequencer_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic          clk,
    input  logic          rst,
    md_sequencer_if.slave bus
);

    localparam int CNT_MAX = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    md_state_e           state_q,  state_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic [DATA_W-1:0]   hi_q,     hi_d;
    logic [DATA_W-1:0]   lo_q,     lo_d;
    logic [2*DATA_W-1:0] prod_q,   prod_d;
    logic [DATA_W-1:0]   rem_q,    rem_d;
    logic [DATA_W-1:0]   quo_q,    quo_d;
    logic [DATA_W-1:0]   dvsr_q,   dvsr_d;
    logic                qsign_q,  qsign_d;
    logic                rsign_q,  rsign_d;

    logic [DATA_W-1:0]   rem_step;
    logic [DATA_W-1:0]   quo_step;
    logic                done;

    md_sequencer_div_step #(
        .DATA_W (DATA_W)
    ) u_div_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvsr_q),
        .rem_o     (rem_step),
        .quo_o     (quo_step)
    );

    // State and datapath registers; reset clears HI/LO and returns to IDLE at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MD_ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            prod_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvsr_q  <= '0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            prod_q  <= prod_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvsr_q  <= dvsr_d;
            qsign_q <= qsign_d;
            rsign_q <= rsign_d;
        end
    end

    // Next-state logic: issue from IDLE, count down while running, commit at cnt==0.
    // A kill beats both issue and commit.
    always_comb begin
        logic                sgn;
        logic [2*DATA_W-1:0] ext_a;
        logic [2*DATA_W-1:0] ext_b;

        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        prod_d  = prod_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvsr_d  = dvsr_q;
        qsign_d = qsign_q;
        rsign_d = rsign_q;
        done    = 1'b0;

        sgn   = op_is_signed(bus.md_op);
        ext_a = {{DATA_W{sgn & bus.src_a[DATA_W-1]}}, bus.src_a};
        ext_b = {{DATA_W{sgn & bus.src_b[DATA_W-1]}}, bus.src_b};

        case (state_q)
            MD_ST_IDLE: begin
                if (bus.md_valid && !bus.md_kill) begin
                    if (op_is_mul(bus.md_op)) begin
                        state_d = MD_ST_RUN_MUL;
                        cnt_d   = CNT_W'(MUL_CYCLES - 1);
                        // Low 2W bits of the sign-extended product are the
                        // correct result for both signed and unsigned.
                        prod_d  = ext_a * ext_b;
                    end else if (op_is_div(bus.md_op)) begin
                        state_d = MD_ST_RUN_DIV;
                        cnt_d   = CNT_W'(DIV_CYCLES - 1);
                        rem_d   = '0;
                        quo_d   = (sgn && bus.src_a[DATA_W-1]) ? -bus.src_a : bus.src_a;
                        dvsr_d  = (sgn && bus.src_b[DATA_W-1]) ? -bus.src_b : bus.src_b;
                        qsign_d = sgn & (bus.src_a[DATA_W-1] ^ bus.src_b[DATA_W-1]);
                        rsign_d = sgn & bus.src_a[DATA_W-1];
                    end else if (bus.md_op == MD_OP_MTHI) begin
                        hi_d = bus.src_a;
                    end else if (bus.md_op == MD_OP_MTLO) begin
                        lo_d = bus.src_a;
                    end
                end
            end

            MD_ST_RUN_MUL: begin
                if (bus.md_kill) begin
                    state_d = MD_ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    hi_d    = prod_q[2*DATA_W-1:DATA_W];
                    lo_d    = prod_q[DATA_W-1:0];
                    done    = 1'b1;
                    state_d = MD_ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            MD_ST_RUN_DIV: begin
                if (bus.md_kill) begin
                    state_d = MD_ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    rem_d = rem_step;
                    quo_d = quo_step;
                    if (cnt_q == '0) begin
                        // The last step's output is the final magnitude pair.
                        lo_d    = qsign_q ? -quo_step : quo_step;
                        hi_d    = rsign_q ? -rem_step : rem_step;
                        done    = 1'b1;
                        state_d = MD_ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d = MD_ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // MF read port: combinational, zero unless a valid MFHI/MFLO is present.
    always_comb begin
        bus.md_rdata = '0;
        if (bus.md_valid) begin
            if (bus.md_op == MD_OP_MFHI) begin
                bus.md_rdata = hi_q;
            end else if (bus.md_op == MD_OP_MFLO) begin
                bus.md_rdata = lo_q;
            end
        end
    end

    assign bus.md_busy  = (state_q != MD_ST_IDLE);
    assign bus.md_stall = bus.md_valid && (bus.md_op != MD_OP_NOP) && (state_q != MD_ST_IDLE);
    assign bus.md_done  = done;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: hand-computed MULT/DIV results, stall
// timing, kill/reset boundaries and the MT/MF register port.
module tb_md_sequencer;
    import md_sequencer_pkg::*;

    localparam int W       = 32;
    localparam int MUL_CYC = 4;
    localparam int DIV_CYC = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    md_sequencer_if #(.DATA_W(W)) bus ();

    md_sequencer #(
        .DATA_W     (W),
        .MUL_CYCLES (MUL_CYC),
        .DIV_CYCLES (DIV_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic k);
        bus.md_valid = v;
        bus.md_op    = op;
        bus.src_a    = a;
        bus.src_b    = b;
        bus.md_kill  = k;
    endtask

    task automatic run_div(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_lo,
                           input logic [31:0] exp_hi);
        int cyc;
        bit seen;
        drive(1'b1, op, a, b, 1'b0);
        step();
        // Cycle 1: a non-md slot must not stall even though the unit is busy.
        drive(1'b1, MD_OP_NOP, 32'd0, 32'd0, 1'b0);
        #1;
        check_val({tag, "_nop_stall"}, 64'(bus.md_stall), 64'd0);
        check_val({tag, "_busy"}, 64'(bus.md_busy), 64'd1);
        drive(1'b0, MD_OP_NOP, 32'd0, 32'd0, 1'b0);
        cyc  = 1;
        seen = 1'b0;
        while (cyc <= DIV_CYC + 8 && !seen) begin
            if (bus.md_done) seen = 1'b1;
            else begin
                step();
                cyc++;
            end
        end
        check_val({tag, "_done_cycle"}, 64'(cyc), 64'(DIV_CYC));
        step();
        check_val({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
        check_val({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
        check_val({tag, "_idle"}, 64'(bus.md_busy), 64'd0);
        $display("txn %s op=%0d a=0x%08h b=0x%08h -> lo=0x%08h hi=0x%08h done@%0d",
                 tag, op, a, b, bus.lo, bus.hi, cyc);
    endtask

    initial begin
        bit done_seen;

        drive(1'b0, MD_OP_NOP, 32'd0, 32'd0, 1'b0);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        check_val("rst_hi", 64'(bus.hi), 64'd0);
        check_val("rst_lo", 64'(bus.lo), 64'd0);
        check_val("rst_busy", 64'(bus.md_busy), 64'd0);
        check_val("rst_stall", 64'(bus.md_stall), 64'd0);
        check_val("rst_done", 64'(bus.md_done), 64'd0);
        $display("txn reset released");

        // MULT -3 * 7 followed by a dependent MFHI: four stalled cycles.
        step();
        drive(1'b1, MD_OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
        step();
        drive(1'b1, MD_OP_MFHI, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < MUL_CYC; i++) begin
            check_val($sformatf("mul_stall_c%0d", i + 1), 64'(bus.md_stall), 64'd1);
            check_val($sformatf("mul_done_c%0d", i + 1), 64'(bus.md_done), 64'(i == MUL_CYC - 1));
            step();
        end
        check_val("mul_mfhi_stall", 64'(bus.md_stall), 64'd0);
        check_val("mul_mfhi_rdata", 64'(bus.md_rdata), 64'hFFFF_FFFF);
        drive(1'b1, MD_OP_MFLO, 32'd0, 32'd0, 1'b0);
        #1;
        check_val("mul_mflo_rdata", 64'(bus.md_rdata), 64'hFFFF_FFEB);
        $display("txn MULT -3*7 -> hi=0x%08h lo=0x%08h", bus.hi, bus.lo);
        drive(1'b0, MD_OP_NOP, 32'd0, 32'd0, 1'b0);

        // MULTU with large operands: 0xFFFFFFFF * 2 = 0x1_FFFFFFFE.
        step();
        drive(1'b1, MD_OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
        step();
        drive(1'b0, MD_OP_NOP, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < MUL_CYC; i++) step();
        check_val("multu_hi", 64'(bus.hi), 64'd1);
        check_val("multu_lo", 64'(bus.lo), 64'hFFFF_FFFE);
        $display("txn MULTU 0xffffffff*2 -> hi=0x%08h lo=0x%08h", bus.hi, bus.lo);

        // Divides.
        run_div("divu_100_7", MD_OP_DIVU, 32'd100, 32'd7, 32'd14, 32'd2);
        drive(1'b1, MD_OP_MFLO, 32'd0, 32'd0, 1'b0);
        #1;
        check_val("divu_mflo_stall", 64'(bus.md_stall), 64'd0);
        check_val("divu_mflo_rdata", 64'(bus.md_rdata), 64'd14);
        step();
        drive(1'b1, MD_OP_MFHI, 32'd0, 32'd0, 1'b0);
        #1;
        check_val("divu_mfhi_rdata", 64'(bus.md_rdata), 64'd2);
        drive(1'b0, MD_OP_NOP, 32'd0, 32'd0, 1'b0);
        step();

        run_div("div_m7_2", MD_OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_div("div_min_m1", MD_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        run_div("div_5_0", MD_OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);

        // MFHI without md_valid reads zero.
        drive(1'b0, MD_OP_MFHI, 32'd0, 32'd0, 1'b0);
        #1;
        check_val("mfhi_novalid", 64'(bus.md_rdata), 64'd0);

        // MTHI / MTLO, then kill a running DIVU at cycle 10.
        step();
        drive(1'b1, MD_OP_MTHI, 32'h0000_AAAA, 32'd0, 1'b0);
        #1;
        check_val("mthi_old_hi", 64'(bus.hi), 64'd5);
        step();
        drive(1'b1, MD_OP_MTLO, 32'h0000_5555, 32'd0, 1'b0);
        step();
        drive(1'b1, MD_OP_DIVU, 32'd1000, 32'd3, 1'b0);
        step();
        drive(1'b0, MD_OP_NOP, 32'd0, 32'd0, 1'b0);
        for (int i = 1; i < 10; i++) step();
        bus.md_kill = 1'b1;
        #1;
        check_val("kill_done", 64'(bus.md_done), 64'd0);
        step();
        bus.md_kill = 1'b0;
        #1;
        check_val("kill_busy", 64'(bus.md_busy), 64'd0);
        done_seen = 1'b0;
        for (int i = 0; i < DIV_CYC; i++) begin
            if (bus.md_done) done_seen = 1'b1;
            step();
        end
        check_val("kill_no_done", 64'(done_seen), 64'd0);
        check_val("kill_hi", 64'(bus.hi), 64'h0000_AAAA);
        check_val("kill_lo", 64'(bus.lo), 64'h0000_5555);
        $display("txn DIVU killed at cycle 10 -> hi=0x%08h lo=0x%08h", bus.hi, bus.lo);

        // Kill on the completion cycle wins: no commit.
        drive(1'b1, MD_OP_MULT, 32'd2, 32'd3, 1'b0);
        step();
        drive(1'b0, MD_OP_NOP, 32'd0, 32'd0, 1'b0);
        for (int i = 1; i < MUL_CYC; i++) step();
        bus.md_kill = 1'b1;
        #1;
        check_val("killlast_done", 64'(bus.md_done), 64'd0);
        step();
        bus.md_kill = 1'b0;
        #1;
        check_val("killlast_busy", 64'(bus.md_busy), 64'd0);
        check_val("killlast_lo", 64'(bus.lo), 64'h0000_5555);
        $display("txn MULT killed on last cycle -> lo=0x%08h", bus.lo);

        // Kill in IDLE blocks both an MT write and an issue.
        drive(1'b1, MD_OP_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b1);
        step();
        check_val("idlekill_mthi", 64'(bus.hi), 64'h0000_AAAA);
        drive(1'b1, MD_OP_MULT, 32'd2, 32'd3, 1'b1);
        step();
        check_val("idlekill_issue", 64'(bus.md_busy), 64'd0);
        $display("txn kill in IDLE -> hi=0x%08h busy=%0d", bus.hi, bus.md_busy);

        // MTHI then MFHI the next cycle: new value, no stall.
        drive(1'b1, MD_OP_MTHI, 32'h0000_1234, 32'd0, 1'b0);
        #1;
        check_val("mthi_stall", 64'(bus.md_stall), 64'd0);
        step();
        drive(1'b1, MD_OP_MFHI, 32'd0, 32'd0, 1'b0);
        #1;
        check_val("mfhi_after_mthi_stall", 64'(bus.md_stall), 64'd0);
        check_val("mfhi_after_mthi", 64'(bus.md_rdata), 64'h0000_1234);
        $display("txn MTHI 0x1234 / MFHI -> 0x%08h", bus.md_rdata);

        // Asynchronous reset in the middle of a MULT.
        step();
        drive(1'b1, MD_OP_MULT, 32'd3, 32'd5, 1'b0);
        step();
        drive(1'b0, MD_OP_NOP, 32'd0, 32'd0, 1'b0);
        step();
        check_val("pre_rst_busy", 64'(bus.md_busy), 64'd1);
        rst = 1'b1;
        #1;
        check_val("midrst_busy", 64'(bus.md_busy), 64'd0);
        check_val("midrst_hi", 64'(bus.hi), 64'd0);
        check_val("midrst_lo", 64'(bus.lo), 64'd0);
        #1;
        rst = 1'b0;
        $display("txn reset mid-MULT -> busy=%0d hi=0x%08h lo=0x%08h", bus.md_busy, bus.hi, bus.lo);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
